// File: rtl/hex_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_scanner_pkg
//   Shared definitions for the hex display scanner:
//     - default word/address widths and refresh period
//     - frame sequencer state encoding (IDLE..DONE)
//     - blank segment pattern and the 16-entry hex segment table
//   Segment patterns are active-low {g,f,e,d,c,b,a}.
// -----------------------------------------------------------------------------
package hex_display_scanner_pkg;

    localparam int DEFAULT_WORD_WIDTH     = 32;
    localparam int DEFAULT_ADDR_WIDTH     = 8;
    localparam int DEFAULT_REFRESH_CYCLES = 25000000;
    localparam int NUM_DIGITS             = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CLK_LO  = 3'd2,
        ST_CLK_HI  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DECODE  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index = nibble value 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_display_scanner_hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
//   Purely combinational 4-bit to 7-segment decoder (active-low {g,f,e,d,c,b,a}).
//   Ports:
//     nibble  in  4  hex digit value
//     seg     out 7  segment pattern
// -----------------------------------------------------------------------------
module hex_to_7seg
    import hex_display_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
//   Periodically reads one RAM word at base_addr through a two-phase read_clock
//   handshake and shows it as 8 hex digits on HEX7..HEX0 (HEX7 = MS nibble).
//   One nibble is decoded per cycle through a single shared decoder.
//
//   Frame (one cycle per state), started in IDLE at refresh terminal count
//   when hold is low:  IDLE -> ADDR -> CLK_LO -> CLK_HI -> CAPTURE ->
//                      DECODE x8 (digit 7..0) -> DONE -> IDLE
//
//   Ports:
//     clock       in   1           system clock, rising edge
//     reset_n     in   1           asynchronous active-low reset
//     base_addr   in   ADDR_WIDTH  RAM address to display, sampled in ADDR
//     hold        in   1           1 = no new frames start
//     read_from   out  ADDR_WIDTH  RAM read address
//     read_clock  out  1           RAM read clock, idle high, rising edge reads
//     read        in   WORD_WIDTH  RAM read data
//     busy        out  1           high from ADDR through DONE
//     frame_done  out  1           one-cycle pulse in DONE
//     HEX0..HEX7  out  7 each      active-low segment outputs
//
//   Build option: define DISPLAY_BLANK_EN for leading-zero blanking
//   (HEX0 is always decoded so a zero word shows a single "0").
//
//   WORD_WIDTH must be 32 (eight nibbles).
// -----------------------------------------------------------------------------
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int WORD_WIDTH     = DEFAULT_WORD_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  hold,
    output logic [ADDR_WIDTH-1:0] read_from,
    output logic                  read_clock,
    input  logic [WORD_WIDTH-1:0] read,
    output logic                  busy,
    output logic                  frame_done,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3,
    output logic [6:0]            HEX4,
    output logic [6:0]            HEX5,
    output logic [6:0]            HEX6,
    output logic [6:0]            HEX7
);

    localparam int             CNT_WIDTH = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TC_VALUE = CNT_WIDTH'(REFRESH_CYCLES - 1);

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    refresh_cnt_reg;
    logic [ADDR_WIDTH-1:0]   read_from_reg;
    logic                    read_clock_reg;
    logic [WORD_WIDTH-1:0]   shadow_reg;
    logic [2:0]              digit_idx_reg;
    logic [6:0]              hex_reg [NUM_DIGITS];

    logic                    terminal_count;
    logic [3:0]              cur_nibble;
    logic [6:0]              dec_seg;
    logic [6:0]              digit_seg;

    assign terminal_count = (refresh_cnt_reg == TC_VALUE);

    // ---------------------------------------------------------------- counter
    // Free-running: independent of state and hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            refresh_cnt_reg <= '0;
        else if (terminal_count)
            refresh_cnt_reg <= '0;
        else
            refresh_cnt_reg <= refresh_cnt_reg + CNT_WIDTH'(1);
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // A terminal count while held is simply lost: no catch-up later.
            ST_IDLE:    if (terminal_count && !hold) state_next = ST_ADDR;
            ST_ADDR:    state_next = ST_CLK_LO;
            ST_CLK_LO:  state_next = ST_CLK_HI;
            ST_CLK_HI:  state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_DECODE;
            ST_DECODE:  if (digit_idx_reg == 3'd0) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = (state_reg == ST_DONE);

    // ---------------------------------------------------------------- read port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_from_reg  <= '0;
            read_clock_reg <= 1'b1;
        end else begin
            if (state_reg == ST_ADDR)
                read_from_reg <= base_addr;
            if (state_reg == ST_CLK_LO)
                read_clock_reg <= 1'b0;
            else if (state_reg == ST_CLK_HI)
                read_clock_reg <= 1'b1;
        end
    end

    assign read_from  = read_from_reg;
    assign read_clock = read_clock_reg;

    // ---------------------------------------------------------------- capture / digit sequencing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_reg    <= '0;
            digit_idx_reg <= '0;
        end else if (state_reg == ST_CAPTURE) begin
            shadow_reg    <= read;
            digit_idx_reg <= 3'd7;
        end else if (state_reg == ST_DECODE) begin
            digit_idx_reg <= digit_idx_reg - 3'd1;
        end
    end

    assign cur_nibble = shadow_reg[{digit_idx_reg, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef DISPLAY_BLANK_EN
    // seen goes high at the first nonzero nibble of the MSB-first scan; zeros
    // before it are blanked, except digit 0 which always shows.
    logic seen_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            seen_reg <= 1'b0;
        else if (state_reg == ST_CAPTURE)
            seen_reg <= 1'b0;
        else if (state_reg == ST_DECODE && cur_nibble != 4'd0)
            seen_reg <= 1'b1;
    end

    assign digit_seg = (!seen_reg && cur_nibble == 4'd0 && digit_idx_reg != 3'd0)
                       ? SEG_BLANK : dec_seg;
`else
    assign digit_seg = dec_seg;
`endif

    // ---------------------------------------------------------------- digit registers
    // Each digit register loads only in its own DECODE slot and otherwise holds.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    hex_reg[gi] <= SEG_BLANK;
                else if (state_reg == ST_DECODE && digit_idx_reg == 3'(gi))
                    hex_reg[gi] <= digit_seg;
            end
        end
    endgenerate

    assign HEX0 = hex_reg[0];
    assign HEX1 = hex_reg[1];
    assign HEX2 = hex_reg[2];
    assign HEX3 = hex_reg[3];
    assign HEX4 = hex_reg[4];
    assign HEX5 = hex_reg[5];
    assign HEX6 = hex_reg[6];
    assign HEX7 = hex_reg[7];

endmodule

// File: tb/tb_hex_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_hex_display_scanner
//   Directed self-checking bench for hex_display_scanner with REFRESH_CYCLES=16
//   and a behavioural RAM that reads on the rising edge of read_clock.
//   Expectations follow the DISPLAY_BLANK_EN build option when it is defined.
// -----------------------------------------------------------------------------
module tb_hex_display_scanner;

    logic        clock;
    logic        reset_n;
    logic [7:0]  base_addr;
    logic        hold;
    logic [7:0]  read_from;
    logic        read_clock;
    logic [31:0] read;
    logic        busy;
    logic        frame_done;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

    logic [6:0]  hex_obs [8];
    logic [31:0] mem [256];

    int pass_cnt  = 0;
    int check_cnt = 0;

    // per-frame observations from do_frame
    bit         f_timeout;
    int         rc_low;
    int         fd_cnt;
    int         fd_idx;
    logic [6:0] hex7_t5, hex7_t6, hex0_t12, hex0_t13;
    logic [7:0] rf_t13;
    logic       busy_t14;

    hex_display_scanner #(
        .WORD_WIDTH     (32),
        .ADDR_WIDTH     (8),
        .REFRESH_CYCLES (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .base_addr  (base_addr),
        .hold       (hold),
        .read_from  (read_from),
        .read_clock (read_clock),
        .read       (read),
        .busy       (busy),
        .frame_done (frame_done),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .HEX6       (HEX6),
        .HEX7       (HEX7)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge read_clock) read <= mem[read_from];

    assign hex_obs[0] = HEX0;
    assign hex_obs[1] = HEX1;
    assign hex_obs[2] = HEX2;
    assign hex_obs[3] = HEX3;
    assign hex_obs[4] = HEX4;
    assign hex_obs[5] = HEX5;
    assign hex_obs[6] = HEX6;
    assign hex_obs[7] = HEX7;

    // Waits for the next frame (busy rising) and walks t1..t14 on negedges.
    task automatic do_frame(input bit change_base, input logic [7:0] new_base);
        int n;
        f_timeout = 0;
        rc_low = 0;
        fd_cnt = 0;
        fd_idx = -1;
        n = 0;
        while (busy && n < 40) begin @(negedge clock); n++; end
        n = 0;
        while (!busy && n < 40) begin @(negedge clock); n++; end
        if (!busy) begin
            f_timeout = 1;
            return;
        end
        for (int t = 1; t <= 14; t++) begin
            if (read_clock === 1'b0) rc_low++;
            if (frame_done === 1'b1) begin fd_cnt++; fd_idx = t; end
            if (t == 5)  hex7_t5  = HEX7;
            if (t == 6)  hex7_t6  = HEX7;
            if (t == 12) hex0_t12 = HEX0;
            if (t == 13) begin hex0_t13 = HEX0; rf_t13 = read_from; end
            if (t == 14) busy_t14 = busy;
            if (t == 2 && change_base) base_addr = new_base;
            if (t < 14) @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        hold = 1'b0;
        base_addr = 8'd5;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (hex_obs[i] !== 7'h7F)
                $display("FAIL reset_hex%0d: got %h expected 7f", i, hex_obs[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if ({busy, frame_done, read_clock} !== 3'b001)
            $display("FAIL reset_ctrl: busy/frame_done/read_clock=%b expected 001",
                     {busy, frame_done, read_clock});
        else pass_cnt++;
        check_cnt++;
        if (read_from !== 8'd0)
            $display("FAIL reset_read_from: got %h expected 00", read_from);
        else pass_cnt++;
        reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic_frame;
        logic [6:0] exp_hex [8];
        exp_hex = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        do_frame(0, 8'd0);
        check_cnt++;
        if (f_timeout) begin
            $display("FAIL basic_timeout: no frame started");
            return;
        end
        pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (hex_obs[i] !== exp_hex[i])
                $display("FAIL basic_hex%0d: got %h expected %h", i, hex_obs[i], exp_hex[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (fd_cnt !== 1 || fd_idx !== 13)
            $display("FAIL basic_frame_done: count %0d at t%0d expected 1 at t13", fd_cnt, fd_idx);
        else pass_cnt++;
        check_cnt++;
        if (rc_low !== 1)
            $display("FAIL basic_read_clock_low: %0d cycles expected 1", rc_low);
        else pass_cnt++;
        check_cnt++;
        if (hex7_t5 !== 7'h7F || hex7_t6 !== 7'h79)
            $display("FAIL basic_hex7_timing: t5=%h t6=%h expected 7f 79", hex7_t5, hex7_t6);
        else pass_cnt++;
        check_cnt++;
        if (hex0_t12 !== 7'h7F || hex0_t13 !== 7'h21)
            $display("FAIL basic_hex0_timing: t12=%h t13=%h expected 7f 21", hex0_t12, hex0_t13);
        else pass_cnt++;
        check_cnt++;
        if (rf_t13 !== 8'd5 || busy_t14 !== 1'b0)
            $display("FAIL basic_addr_busy: read_from=%h busy_t14=%b expected 05 0", rf_t13, busy_t14);
        else pass_cnt++;
        $display("test_basic_frame done: HEX7..0 = %h %h %h %h %h %h %h %h",
                 HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
    endtask

    // Called at t14 of a frame: terminal counts fall at t16, t32, t48.
    task automatic test_hold;
        int rc_toggles, fds, busys, n;
        logic [6:0] exp_hex [8];
        exp_hex = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        rc_toggles = 0; fds = 0; busys = 0;
        hold = 1'b1;
        repeat (33) begin
            @(negedge clock);
            if (read_clock !== 1'b1) rc_toggles++;
            if (frame_done !== 1'b0) fds++;
            if (busy !== 1'b0) busys++;
        end
        check_cnt++;
        if (rc_toggles != 0 || fds != 0 || busys != 0)
            $display("FAIL hold_activity: read_clock_low=%0d frame_done=%0d busy=%0d expected 0 0 0",
                     rc_toggles, fds, busys);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (hex_obs[i] !== exp_hex[i])
                $display("FAIL hold_hex%0d: got %h expected %h", i, hex_obs[i], exp_hex[i]);
            else pass_cnt++;
        end
        hold = 1'b0;
        n = 0;
        while (!busy && n < 40) begin @(negedge clock); n++; end
        check_cnt++;
        if (n !== 2)
            $display("FAIL hold_release_start: busy after %0d cycles expected 2", n);
        else pass_cnt++;
        n = 0;
        while (busy && n < 40) begin @(negedge clock); n++; end
        $display("test_hold done");
    endtask

    task automatic test_blank_pattern;
        logic [6:0] exp_hex [8];
`ifdef DISPLAY_BLANK_EN
        exp_hex = '{7'h40, 7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
        exp_hex = '{7'h40, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
        base_addr = 8'd2;
        do_frame(0, 8'd0);
        check_cnt++;
        if (f_timeout) begin
            $display("FAIL blank_timeout: no frame started");
            return;
        end
        pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (hex_obs[i] !== exp_hex[i])
                $display("FAIL blank_hex%0d: got %h expected %h", i, hex_obs[i], exp_hex[i]);
            else pass_cnt++;
        end
        $display("test_blank_pattern done: HEX7..0 = %h %h %h %h %h %h %h %h",
                 HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
    endtask

    task automatic test_zero_word;
        logic [6:0] exp_hex [8];
`ifdef DISPLAY_BLANK_EN
        exp_hex = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
        exp_hex = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
        base_addr = 8'd0;
        do_frame(0, 8'd0);
        check_cnt++;
        if (f_timeout) begin
            $display("FAIL zero_timeout: no frame started");
            return;
        end
        pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (hex_obs[i] !== exp_hex[i])
                $display("FAIL zero_hex%0d: got %h expected %h", i, hex_obs[i], exp_hex[i]);
            else pass_cnt++;
        end
        $display("test_zero_word done: HEX7..0 = %h %h %h %h %h %h %h %h",
                 HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
    endtask

    task automatic test_base_change;
        logic [6:0] exp5 [8];
        logic [6:0] exp6 [8];
        exp5 = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        exp6 = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        base_addr = 8'd5;
        do_frame(1, 8'd6);
        check_cnt++;
        if (f_timeout) begin
            $display("FAIL base_change_timeout: no frame started");
            return;
        end
        pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (hex_obs[i] !== exp5[i])
                $display("FAIL base_old_hex%0d: got %h expected %h", i, hex_obs[i], exp5[i]);
            else pass_cnt++;
        end
        do_frame(0, 8'd0);
        check_cnt++;
        if (f_timeout) begin
            $display("FAIL base_next_timeout: no frame started");
            return;
        end
        pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (hex_obs[i] !== exp6[i])
                $display("FAIL base_new_hex%0d: got %h expected %h", i, hex_obs[i], exp6[i]);
            else pass_cnt++;
        end
        $display("test_base_change done: HEX7..0 = %h %h %h %h %h %h %h %h",
                 HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
    endtask

    task automatic test_reset_mid_frame;
        int n;
        n = 0;
        while (busy && n < 40) begin @(negedge clock); n++; end
        n = 0;
        while (!busy && n < 40) begin @(negedge clock); n++; end
        check_cnt++;
        if (!busy) begin
            $display("FAIL midreset_timeout: no frame started");
            return;
        end
        pass_cnt++;
        repeat (7) @(negedge clock);      // now at t8, mid-DECODE
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (hex_obs[i] !== 7'h7F)
                $display("FAIL midreset_hex%0d: got %h expected 7f", i, hex_obs[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if ({busy, frame_done, read_clock} !== 3'b001)
            $display("FAIL midreset_ctrl: busy/frame_done/read_clock=%b expected 001",
                     {busy, frame_done, read_clock});
        else pass_cnt++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (busy) break;
        end
        check_cnt++;
        if (n !== 16)
            $display("FAIL midreset_first_frame: busy after %0d cycles expected 16", n);
        else pass_cnt++;
        n = 0;
        while (busy && n < 40) begin @(negedge clock); n++; end
        check_cnt++;
        if (HEX7 !== 7'h00 || HEX0 !== 7'h0E)
            $display("FAIL midreset_refresh: HEX7=%h HEX0=%h expected 00 0e", HEX7, HEX0);
        else pass_cnt++;
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
        mem[0] = 32'h0000_0000;
        mem[2] = 32'h0000_00F0;
        mem[5] = 32'h1234_ABCD;
        mem[6] = 32'h89AB_CDEF;
        read = 32'h0;

        test_reset();
        test_basic_frame();
        test_hold();
        test_blank_pattern();
        test_zero_word();
        test_base_change();
        test_reset_mid_frame();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
